// File: rtl/serial_full_adder_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_full_adder_mux                                           |
// | Brief    : Bit-serial WIDTH-bit adder, one bit per clock through a         |
// |            mux-built full-adder cell with a registered carry.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module serial_full_adder_mux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    // Holds the first WIDTH-1 result bits; the final bit goes straight to sum.
    logic [WIDTH-2:0] r_res;
    logic             r_carry;
    logic [c_CW-1:0]  r_cnt;

    logic             w_x;
    logic             w_y;
    logic             w_yc;
    logic             w_s;
    logic             w_co;
    logic [WIDTH-2:0] w_res_shift;

    // Full-adder cell as two 2:1 muxes selected by the a bit.
    assign w_x  = r_a_sr[0];
    assign w_y  = r_b_sr[0];
    assign w_yc = w_y ^ r_carry;
    assign w_s  = w_x ? ~w_yc : w_yc;
    assign w_co = w_x ? (w_y | r_carry) : (w_y & r_carry);

    generate
        if (WIDTH > 2) begin : g_res_wide
            assign w_res_shift = {w_s, r_res[WIDTH-2:1]};
        end else begin : g_res_narrow
            assign w_res_shift = w_s;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_res   <= '0;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_res   <= w_res_shift;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + c_CW'(1);
                    if (r_cnt == c_LAST) begin
                        sum     <= {w_s, r_res};
                        cout    <= w_co;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_full_adder_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_full_adder_mux                                        |
// | Brief    : Directed table-driven bench for the 8-bit adder plus an         |
// |            exhaustive sweep of a 4-bit instance.                           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_serial_full_adder_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8, busy8, done8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic [3:0] sum4;
    logic       cout4, busy4, done4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_full_adder_mux #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
    );

    serial_full_adder_mux #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .cout(cout4), .busy(busy4), .done(done4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] held_sum;
    logic       held_cout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the done cycle.
    // poke >= 0 re-asserts start (with junk operands) that many cycles into the op.
    task automatic run8(input logic [7:0] a_i, input logic [7:0] b_i, input logic cin_i,
                        input logic [7:0] es, input logic ec, input int poke, input string name);
        logic ok_busy, ok_hold;
        ok_busy = 1'b1;
        ok_hold = 1'b1;
        start8 = 1'b1; a8 = a_i; b8 = b_i; cin8 = cin_i;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            if (busy8 !== 1'b1 || done8 !== 1'b0) ok_busy = 1'b0;
            if (sum8 !== held_sum || cout8 !== held_cout) ok_hold = 1'b0;
            if (i == poke) begin
                start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        chk({name, " busy"}, {31'd0, ok_busy}, 32'd1);
        chk({name, " hold"}, {31'd0, ok_hold}, 32'd1);
        chk({name, " done"}, {30'd0, done8, busy8}, 32'b10);
        chk({name, " result"}, {23'd0, cout8, sum8}, {23'd0, ec, es});
        held_sum  = es;
        held_cout = ec;
    endtask

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        held_sum  = 8'h00;
        held_cout = 1'b0;

        #2;
        chk("reset outputs", {21'd0, sum8, cout8, busy8, done8}, 32'd0);
        chk("reset outputs w4", {25'd0, sum4, cout4, busy4, done4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run8(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].exp_sum, vecs[v].exp_cout, -1,
                 $sformatf("vec%0d", v));
            @(negedge clk);
            chk($sformatf("vec%0d done clears", v), {30'd0, done8, busy8}, 32'd0);
        end

        // Start while busy is ignored and does not stretch the operation.
        run8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 2, "start-while-busy");
        @(negedge clk);
        chk("swb after", {30'd0, done8, busy8}, 32'd0);
        @(negedge clk);
        chk("swb idle", {30'd0, done8, busy8}, 32'd0);

        // Back-to-back: second start lands in the done cycle of the first.
        run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, -1, "b2b first");
        run8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, -1, "b2b second");
        @(negedge clk);

        // Reset between edges 4 and 5 of an operation.
        begin
            logic saw_done;
            saw_done = 1'b0;
            start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
            @(negedge clk);
            start8 = 1'b0;
            repeat (4) @(negedge clk);
            #1 rst = 1'b1;
            #1;
            chk("async reset", {21'd0, sum8, cout8, busy8, done8}, 32'd0);
            repeat (12) begin
                @(negedge clk);
                if (done8) saw_done = 1'b1;
            end
            rst = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (done8) saw_done = 1'b1;
            end
            chk("no done after reset", {31'd0, saw_done}, 32'd0);
            held_sum  = 8'h00;
            held_cout = 1'b0;
            run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, -1, "post-reset");
            @(negedge clk);
        end

        // Exhaustive WIDTH=4 sweep.
        for (int n = 0; n < 512; n++) begin
            logic [8:0] nv;
            logic [4:0] exp5, got5;
            int dcount;
            nv = 9'(n);
            got5 = '0;
            dcount = 0;
            start4 = 1'b1; a4 = nv[3:0]; b4 = nv[7:4]; cin4 = nv[8];
            exp5 = {1'b0, nv[3:0]} + {1'b0, nv[7:4]} + {4'd0, nv[8]};
            @(negedge clk);
            start4 = 1'b0;
            for (int k = 0; k < 6; k++) begin
                if (done4) begin
                    dcount++;
                    got5 = {cout4, sum4};
                end
                @(negedge clk);
            end
            chk($sformatf("w4 sum %0d", n), {27'd0, got5}, {27'd0, exp5});
            chk($sformatf("w4 done count %0d", n), 32'(dcount), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_full_adder_mux.md
# serial_full_adder_mux

Bit-serial N-bit adder that adds two operands one bit per clock through a single mux-built full-adder cell, with a registered carry. It is the addition counterpart of the mux-based full subtractor in the arithmetic building-block set. It gives a small-area adder for the FPGA exercises, with a start/busy/done handshake so a controller or testbench can sequence operations.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  first operand; captured on the accepted start edge.
- b  input  WIDTH  second operand; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- sum  output  WIDTH  registered result; updated only on completion and held until the next completion.
- cout  output  1  registered carry-out; updated with sum.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse on the cycle after the final bit is processed.

## Operation
- States: IDLE and SHIFT.
- IDLE, start=1 at an edge:
  - load the a and b shift registers;
  - carry ← cin, bit counter ← 0;
  - busy ← 1, go to SHIFT.
- IDLE, start=0: hold all state; done ← 0.
- SHIFT, every edge:
  - take bit x = a_sr[0], y = b_sr[0], c = carry;
  - compute s = x ? ~(y^c) : (y^c) and co = x ? (y|c) : (y&c). These are two 2:1 mux selections with a as the select.
  - shift a_sr and b_sr right by one;
  - shift the internal result register right by one, inserting s at bit WIDTH-1;
  - carry ← co, counter ← counter+1.
- SHIFT, edge where counter = WIDTH-1 (the final bit):
  - sum ← the completed result, i.e. the shifted-in value including this edge's s;
  - cout ← co, done ← 1, busy ← 0;
  - go to IDLE.
- Result is exact: {cout,sum} = a + b + cin, with WIDTH+1 bits and no truncation.
- start while busy is ignored; it is not queued, and the operands on the bus are not captured.
- Inputs a, b and cin may change freely after the accepted start edge.
- Counter width is $clog2(WIDTH). It never wraps within an operation, because it is cleared on every accept.

## Timing
- Reset, asynchronous, effective immediately, all registers cleared:
  - sum = 0, cout = 0, busy = 0, done = 0;
  - state = IDLE, carry = 0, counter = 0, shift registers = 0.
- Reset mid-operation: the operation is abandoned and no done pulse is produced. sum and cout read 0, not the previous result.
- Reset release: the first start is accepted on the first rising edge with rst = 0.
- Latency, with the start edge counted as edge 0:
  - busy = 1 after edge 0 through edge WIDTH-1;
  - the bit processed at edge k is bit k-1;
  - after edge WIDTH: busy = 0, done = 1, and sum/cout are valid.
- Total latency is WIDTH+1 edges from accepted start to done.
- done is high for exactly one cycle. It clears on the next edge unless another operation completes on that edge, which is impossible for WIDTH ≥ 2.
- Back-to-back operation: start = 1 during the done cycle is accepted, since the state is IDLE. sum/cout keep the previous result until the new operation completes. Throughput is one addition per WIDTH+1 cycles.
- sum and cout never show partial results.

## Test plan
- Basic add: WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start → busy high for 8 cycles, then done pulse; sum=0x96, cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Separately, a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start while busy: a=0x01, b=0x02 started; 3 cycles later, start with a=0xF0, b=0x0F → second start ignored; single done with sum=0x03, cout=0; busy never extends.
- Back-to-back: a=0x10, b=0x20 → on its done cycle, assert start with a=0x80, b=0x80, cin=1. Required response:
  - sum=0x30 held through the second operation;
  - the second done comes 9 edges later with sum=0x01, cout=1.
- Reset mid-operation: start a=0xAA, b=0x55, then assert rst asynchronously between edges 4 and 5 → outputs go to 0 immediately and there is no done pulse. After release, a fresh a=0x01, b=0x01 gives sum=0x02.
- Exhaustive/random check: WIDTH=4, all 512 combinations of a, b and cin → {cout,sum} equals a+b+cin every time, and done pulses exactly once per start.
